// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, CPU first with bounded DMA bursts and starvation override
module mem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpuMemAddr,
  input  logic        cpuMemRe,
  input  logic        cpuMemWe,
  input  logic [15:0] cpuWData,
  output logic [15:0] cpuRData,
  output logic        cpuStall,
  input  logic        dmaReq,
  input  logic [15:0] dmaAddr,
  input  logic        dmaWe,
  input  logic [15:0] dmaWData,
  input  logic        dmaBurst,
  output logic        dmaGnt,
  output logic [15:0] dmaRData,
  output logic [15:0] memAddr,
  output logic        memRe,
  output logic        memWe,
  output logic [15:0] memWBus,
  input  logic [15:0] memRBus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

  owner_e          owner_q, owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;

  logic cpu_req;
  logic lock;
  logic gnt_cpu;
  logic gnt_dma;

  assign cpu_req = cpuMemRe | cpuMemWe;
  assign lock    = (owner_q == OWN_DMA) & dmaBurst & (burst_cnt_q < BURST_MAX);

  // Grant decision: starved or locked DMA, then CPU, then idle-slot DMA; nothing while in reset
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!rst) begin
      if (dmaReq && ((wait_cnt_q == WAIT_MAX) || lock)) begin
        gnt_dma = 1'b1;
      end else if (cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (dmaReq) begin
        gnt_dma = 1'b1;
      end
    end
  end

  // Memory-side mux; a CPU asserting both read and write performs the write
  always_comb begin
    memAddr = 16'h0000;
    memWBus = 16'h0000;
    memRe   = 1'b0;
    memWe   = 1'b0;
    if (gnt_cpu) begin
      memAddr = cpuMemAddr;
      memWBus = cpuWData;
      memWe   = cpuMemWe;
      memRe   = cpuMemRe & ~cpuMemWe;
    end else if (gnt_dma) begin
      memAddr = dmaAddr;
      memWBus = dmaWData;
      memWe   = dmaWe;
      memRe   = ~dmaWe;
    end
  end

  assign cpuRData = memRBus;
  assign dmaRData = memRBus;
  assign cpuStall = cpu_req & ~gnt_cpu & ~rst;
  assign dmaGnt   = gnt_dma;

  // Next-state: remember owner, saturate burst length and denied-wait counters
  always_comb begin
    owner_d     = gnt_dma ? OWN_DMA : (gnt_cpu ? OWN_CPU : OWN_NONE);
    burst_cnt_d = '0;
    wait_cnt_d  = '0;
    if (gnt_dma) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + BW'(1);
    end
    if (dmaReq && !gnt_dma) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WW'(1);
    end
  end

  // State registers with synchronous reset; reset drops any DMA ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpuMemAddr;
  logic        cpuMemRe;
  logic        cpuMemWe;
  logic [15:0] cpuWData;
  logic [15:0] cpuRData;
  logic        cpuStall;
  logic        dmaReq;
  logic [15:0] dmaAddr;
  logic        dmaWe;
  logic [15:0] dmaWData;
  logic        dmaBurst;
  logic        dmaGnt;
  logic [15:0] dmaRData;
  logic [15:0] memAddr;
  logic        memRe;
  logic        memWe;
  logic [15:0] memWBus;
  logic [15:0] memRBus;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        gnt;
    logic        stall;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wbus;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t exp_q[$];

  mem_arbiter #(.MAX_BURST(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpuMemAddr(cpuMemAddr), .cpuMemRe(cpuMemRe), .cpuMemWe(cpuMemWe),
    .cpuWData(cpuWData), .cpuRData(cpuRData), .cpuStall(cpuStall),
    .dmaReq(dmaReq), .dmaAddr(dmaAddr), .dmaWe(dmaWe), .dmaWData(dmaWData),
    .dmaBurst(dmaBurst), .dmaGnt(dmaGnt), .dmaRData(dmaRData),
    .memAddr(memAddr), .memRe(memRe), .memWe(memWe), .memWBus(memWBus),
    .memRBus(memRBus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write at the edge
  assign memRBus = mem[memAddr];
  always @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWBus;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".dmaGnt"},   {15'd0, dmaGnt},   {15'd0, e.gnt});
        chk({e.name, ".cpuStall"}, {15'd0, cpuStall}, {15'd0, e.stall});
        chk({e.name, ".memRe"},    {15'd0, memRe},    {15'd0, e.re});
        chk({e.name, ".memWe"},    {15'd0, memWe},    {15'd0, e.we});
        chk({e.name, ".memAddr"},  memAddr,           e.addr);
        chk({e.name, ".memWBus"},  memWBus,           e.wbus);
        if (e.chk_rd) begin
          if (e.gnt) chk({e.name, ".dmaRData"}, dmaRData, e.rd);
          else       chk({e.name, ".cpuRData"}, cpuRData, e.rd);
        end
      end
    end
  end

  task automatic drive(input logic r,
                       input logic cre, input logic cwe, input logic [15:0] ca, input logic [15:0] cwd,
                       input logic dreq, input logic dwe, input logic [15:0] da, input logic [15:0] dwd,
                       input logic db);
    @(posedge clk);
    #1;
    rst = r;
    cpuMemRe = cre; cpuMemWe = cwe; cpuMemAddr = ca; cpuWData = cwd;
    dmaReq = dreq; dmaWe = dwe; dmaAddr = da; dmaWData = dwd; dmaBurst = db;
  endtask

  task automatic expect_cyc(input string nm, input logic g, input logic s, input logic re, input logic we,
                            input logic [15:0] a, input logic [15:0] wb, input logic crd, input logic [15:0] rd);
    exp_t e;
    e.name = nm; e.gnt = g; e.stall = s; e.re = re; e.we = we;
    e.addr = a; e.wbus = wb; e.chk_rd = crd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    cpuMemRe = 1'b0; cpuMemWe = 1'b0; cpuMemAddr = 16'h0; cpuWData = 16'h0;
    dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = 16'h0; dmaWData = 16'h0; dmaBurst = 1'b0;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0020] = 16'h5A5A;

    // Reset with both requesting: everything held off
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 0);
      expect_cyc("reset", 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    end

    // Starvation: CPU wins 8 cycles, DMA forced on 9th, CPU again on 10th
    for (int c = 1; c <= 10; c++) begin
      drive(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 0);
      if (c == 9) expect_cyc($sformatf("starve_c%0d", c), 1, 1, 1, 0, 16'h0020, 16'h0, 1, 16'h5A5A);
      else        expect_cyc($sformatf("starve_c%0d", c), 0, 0, 1, 0, 16'h0010, 16'h0, 1, 16'hA5A5);
    end

    // Burst cap with DMA write straight through
    drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    expect_cyc("rst2", 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h1234, 16'hBEEF, 1);
    expect_cyc("burst_c1", 1, 0, 0, 1, 16'h1234, 16'hBEEF, 0, 16'h0);
    for (int c = 2; c <= 4; c++) begin
      drive(0, 1, 0, 16'h1234, 16'h0, 1, 1, 16'h1234, 16'hBEEF, 1);
      expect_cyc($sformatf("burst_c%0d", c), 1, 1, 0, 1, 16'h1234, 16'hBEEF, 0, 16'h0);
    end
    drive(0, 1, 0, 16'h1234, 16'h0, 0, 1, 16'h1234, 16'hBEEF, 1);
    expect_cyc("burst_c5", 0, 0, 1, 0, 16'h1234, 16'h0, 1, 16'hBEEF);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    expect_cyc("idle", 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    // CPU read+write together: write wins, then read back
    drive(0, 1, 1, 16'h0030, 16'h1111, 0, 0, 16'h0, 16'h0, 0);
    expect_cyc("cpu_rw", 0, 0, 0, 1, 16'h0030, 16'h1111, 0, 16'h0);
    drive(0, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    expect_cyc("cpu_rd30", 0, 0, 1, 0, 16'h0030, 16'h0, 1, 16'h1111);

    // Reset mid-burst: ownership dropped, DMA only returns via starvation
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0, 1);
    expect_cyc("mid_b1", 1, 0, 1, 0, 16'h0020, 16'h0, 1, 16'h5A5A);
    drive(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1);
    expect_cyc("mid_b2", 1, 1, 1, 0, 16'h0020, 16'h0, 1, 16'h5A5A);
    drive(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1);
    expect_cyc("mid_rst", 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    for (int c = 1; c <= 9; c++) begin
      drive(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1);
      if (c == 9) expect_cyc($sformatf("mid_c%0d", c), 1, 1, 1, 0, 16'h0020, 16'h0, 1, 16'h5A5A);
      else        expect_cyc($sformatf("mid_c%0d", c), 0, 0, 1, 0, 16'h0010, 16'h0, 1, 16'hA5A5);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port memory between two requesters: the CPU control unit (requester 0) and a DMA/debug loader (requester 1).
- Sits between both requesters and the memory block, and drives the memory's memAddr/memRe/memWe/memWBus.
- The CPU is stalled through cpuStall, which control folds into clkHold.
- Priority: CPU first, with bounded DMA bursts and a starvation override.

Parameters:
MAX_BURST, 4, max consecutive DMA grants while CPU is requesting (>=1)
MAX_WAIT, 8, consecutive denied DMA request cycles before DMA is forced priority (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cpuMemAddr  input  16  CPU address
cpuMemRe  input  1  CPU read request
cpuMemWe  input  1  CPU write request
cpuWData  input  16  CPU write data
cpuRData  output  16  CPU read data, valid when CPU granted
cpuStall  output  1  CPU requesting but not granted this cycle
dmaReq  input  1  DMA request, level
dmaAddr  input  16  DMA address
dmaWe  input  1  1=write, 0=read
dmaWData  input  16  DMA write data
dmaBurst  input  1  DMA wants to keep ownership
dmaGnt  output  1  DMA access performed this cycle
dmaRData  output  16  DMA read data, valid when dmaGnt=1
memAddr  output  16  to memory
memRe  output  1  to memory
memWe  output  1  to memory
memWBus  output  16  to memory write bus
memRBus  input  16  memory read data (combinational read)

Behaviour:
- Memory contract: read data is combinational on memRBus in the cycle memRe=1. A write commits at the clk edge while memWe=1. Exactly one access per cycle.
- cpuReq = cpuMemRe | cpuMemWe. If the CPU asserts both, the write wins (memRe=0).
- Requesters hold address, data and control stable until granted. For the CPU, this means until cpuStall=0. For the DMA, this means until dmaGnt is sampled high at a clk edge.
- State registers:
  - owner: NONE/CPU/DMA, the grant of the previous cycle.
  - burstCnt: 0..MAX_BURST.
  - waitCnt: 0..MAX_WAIT.
- lock = (owner==DMA) & dmaBurst & (burstCnt < MAX_BURST).
- Grant decision is combinational, in this priority order:
  1. dmaReq & (waitCnt==MAX_WAIT | lock) -> DMA.
  2. cpuReq -> CPU.
  3. dmaReq -> DMA.
  4. Otherwise -> none.
- Memory-side mux:
  - CPU grant: memAddr=cpuMemAddr, memWBus=cpuWData, memRe/memWe from the CPU.
  - DMA grant: memAddr=dmaAddr, memWBus=dmaWData, memWe=dmaWe, memRe=~dmaWe.
  - No grant: memRe=memWe=0, memAddr=0, memWBus=0.
- cpuRData = dmaRData = memRBus, passed through unconditionally. Each is meaningful only when its requester is granted.
- cpuStall = cpuReq & ~CPU grant. dmaGnt = DMA grant.
- Sequential update at each clk edge:
  - owner <= this cycle's grant.
  - burstCnt <= (DMA grant) ? min(burstCnt+1, MAX_BURST) : 0.
  - waitCnt <= (dmaReq & ~dmaGnt) ? min(waitCnt+1, MAX_WAIT) : 0.
- Guarantees:
  - While the CPU requests continuously, the DMA gets at most MAX_BURST consecutive grants.
  - A requesting DMA waits at most MAX_WAIT cycles.
- Reset, sampled at the clk edge:
  - owner=NONE, burstCnt=0, waitCnt=0.
  - While rst=1, all grant outputs are forced to 0: dmaGnt=0, cpuStall=0, memRe=memWe=0, memAddr=0, memWBus=0.
  - Reset mid-burst drops ownership. The first cycle after reset uses the plain priority order (CPU first).
- dmaReq dropping mid-burst: no grant goes to DMA, burstCnt clears next edge, waitCnt clears.
- DMA writes with the CPU idle go straight through, with no extra latency.

Test Plan:
- Reset: rst=1 with cpuMemRe=1 and dmaReq=1 -> memRe=memWe=0, dmaGnt=0, cpuStall=0. In the first cycle after release, the CPU is granted.
- CPU read alone: cpuMemRe=1, cpuMemAddr=0x0010, memory returns 0xA5A5 -> memRe=1, memAddr=0x0010, cpuRData=0xA5A5, cpuStall=0 in the same cycle.
- Starvation: cpuMemRe=1 and dmaReq=1 (dmaBurst=0) held every cycle from reset release:
  - Cycles 1-8 -> CPU granted, dmaGnt=0.
  - Cycle 9 -> dmaGnt=1, cpuStall=1.
  - Cycle 10 -> CPU again, waitCnt=1.
- Burst cap: dmaReq=1, dmaBurst=1, CPU idle in cycle 1, cpuMemRe=1 from cycle 2 -> dmaGnt=1 in cycles 1-4, CPU granted in cycle 5, cpuStall=1 in cycles 2-4.
- DMA write: CPU idle, dmaReq=1, dmaWe=1, dmaAddr=0x1234, dmaWData=0xBEEF -> memWe=1, memRe=0, memAddr=0x1234, memWBus=0xBEEF, dmaGnt=1 in the same cycle. A CPU read of 0x1234 afterwards returns 0xBEEF.
- Reset mid-burst: rst pulsed after the second DMA burst grant, with both requesters still active -> CPU granted in the first cycle after reset. The DMA then gets its next grant only via starvation, after 8 waits.
